// File: rtl/rv32i_types.sv
// Shared RV32I types for the MEM stage: load/store funct3 codes, MEM FSM state, data-memory request payload.
package rv32i_types;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned DMEM_AW = 32;
   localparam int unsigned BE_W    = 4;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } store_funct3_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      DONE = 2'b10
   } mem_state_t;

   typedef struct packed {
      logic               read;
      logic               write;
      logic [DMEM_AW-1:0] address;
      logic [XLEN-1:0]    wdata;
      logic [BE_W-1:0]    byte_enable;
   } dmem_req_t;

   // Halves must sit on even bytes and words on word boundaries; a write wins over a read.
   function automatic logic is_misaligned(input logic rd, input logic wr,
                                          input load_funct3_t lop, input store_funct3_t sop,
                                          input logic [1:0] a);
      logic mis;
      mis = 1'b0;
      if (wr) begin
         mis = ((sop == SH) && a[0]) || ((sop == SW) && (a != 2'b00));
      end else if (rd) begin
         mis = (((lop == LH) || (lop == LHU)) && a[0]) || ((lop == LW) && (a != 2'b00));
      end
      return mis;
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Single-port data-memory bus: the MEM stage is master, the memory is slave.
interface mem_access_stage_if;
   import rv32i_types::*;

   logic               dmem_read;
   logic               dmem_write;
   logic [DMEM_AW-1:0] dmem_address;
   logic [XLEN-1:0]    dmem_wdata;
   logic [BE_W-1:0]    dmem_byte_enable;
   logic               dmem_resp;
   logic [XLEN-1:0]    dmem_rdata;

   modport master (
      output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
      input  dmem_resp, dmem_rdata
   );

   modport slave (
      input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
      output dmem_resp, dmem_rdata
   );
endinterface

// File: rtl/mem_access_stage_align.sv
// Combinational lane logic: store byte enables / lane-replicated wdata and load extraction with extension.
module mem_align
   import rv32i_types::*;
(
   input  logic [1:0]      addr,
   input  load_funct3_t    loadop,
   input  store_funct3_t   storeop,
   input  logic [XLEN-1:0] rs2,
   input  logic [XLEN-1:0] rdata,
   output logic [BE_W-1:0] byte_enable,
   output logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rdata[{addr, 3'b000} +: 8];
   assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

   // Store lanes
   always_comb begin
      byte_enable = '0;
      wdata       = rs2;
      case (storeop)
         SB: begin
            byte_enable = 4'b0001 << addr;
            wdata       = {4{rs2[7:0]}};
         end
         SH: begin
            byte_enable = addr[1] ? 4'b1100 : 4'b0011;
            wdata       = {2{rs2[15:0]}};
         end
         SW: byte_enable = 4'b1111;
         default: byte_enable = '0;
      endcase
   end

   // Load extraction
   always_comb begin
      load_data = rdata;
      case (loadop)
         LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
         LBU: load_data = {24'h000000, byte_sel};
         LH:  load_data = {{16{half_sel[15]}}, half_sel};
         LHU: load_data = {16'h0000, half_sel};
         default: load_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues data-memory requests, stalls until resp, registers extended load data.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_access_stage
   import rv32i_types::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                MEM_valid,
   input  logic                MEM_read,
   input  logic                MEM_write,
   input  load_funct3_t        MEM_loadop,
   input  store_funct3_t       MEM_storeop,
   input  logic [ADDR_W-1:0]   MEM_alu_out,
   input  logic [XLEN-1:0]     MEM_rs2_out,
   mem_access_stage_if.master  mem_bus,
   output logic                MEM_stall,
   output logic [XLEN-1:0]     MEM_load_data,
   output logic                MEM_misaligned
);

   mem_state_t      state_q, state_d;
   dmem_req_t       req_q;
   logic            access_c;
   logic            misalign_c;
   logic            issue_c;
   logic [BE_W-1:0] align_be;
   logic [XLEN-1:0] align_wdata;
   logic [XLEN-1:0] align_load;

   mem_align u_align (
      .addr        (MEM_alu_out[1:0]),
      .loadop      (MEM_loadop),
      .storeop     (MEM_storeop),
      .rs2         (MEM_rs2_out),
      .rdata       (mem_bus.dmem_rdata),
      .byte_enable (align_be),
      .wdata       (align_wdata),
      .load_data   (align_load)
   );

   assign access_c = MEM_valid & (MEM_read | MEM_write);

`ifdef MEM_MISALIGN_CHECK_EN
   assign misalign_c = access_c &
                       is_misaligned(MEM_read, MEM_write, MEM_loadop, MEM_storeop, MEM_alu_out[1:0]);
`else
   assign misalign_c = 1'b0;
`endif

   assign issue_c = access_c & ~misalign_c;

   // Stall is combinational in IDLE so the pipeline freezes in the same cycle the access appears.
   assign MEM_stall      = ((state_q == IDLE) & issue_c) | (state_q == WAIT);
   assign MEM_misaligned = (state_q == IDLE) & misalign_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (issue_c) state_d = WAIT;
         WAIT:    if (mem_bus.dmem_resp) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request and load-data registers; request fields stay frozen for the whole WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q         <= '0;
         MEM_load_data <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (issue_c) begin
                  req_q.read        <= MEM_read & ~MEM_write;
                  req_q.write       <= MEM_write;
                  req_q.address     <= {MEM_alu_out[ADDR_W-1:2], 2'b00};
                  req_q.wdata       <= align_wdata;
                  req_q.byte_enable <= MEM_write ? align_be : '0;
               end
            end
            WAIT: begin
               if (mem_bus.dmem_resp) begin
                  req_q.read  <= 1'b0;
                  req_q.write <= 1'b0;
                  if (req_q.read) MEM_load_data <= align_load;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_bus.dmem_read        = req_q.read;
   assign mem_bus.dmem_write       = req_q.write;
   assign mem_bus.dmem_address     = req_q.address;
   assign mem_bus.dmem_wdata       = req_q.wdata;
   assign mem_bus.dmem_byte_enable = req_q.byte_enable;

endmodule
